// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 32-entry general-purpose register file for a single-cycle
//                MIPS datapath. Two combinational read ports, one synchronous
//                write port, hardwired $zero, and optional same-cycle
//                write-to-read forwarding. After reset the array is cleared by
//                a sequential sweep (one entry per clock) so the storage can
//                map to RAM without a per-entry reset.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                RegWrite, WriteReg, WriteData - write port
//                ReadReg1/ReadData1 - read port 1 (combinational)
//                ReadReg2/ReadData2 - read port 2 (combinational)
//                Ready              - 1 once the clear sweep has finished
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              Ready
);

    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_run;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_fwd1;
    logic              w_fwd2;

    assign w_run = (r_state == c_ST_RUN);

    // Ready comes straight from the state flop: no path from any input.
    assign Ready = w_run;

    // ------------------------------------------------------------------
    // Control: CLEAR sweep then RUN. The pointer restarts on every reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_CLEAR;
            r_clr_ptr <= '0;
        end else if (!w_run) begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            if (r_clr_ptr == c_LAST_IDX) begin
                r_state <= c_ST_RUN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Single shared write port: the sweep owns it during CLEAR (user writes
    // are dropped, not deferred); in RUN it carries user writes, except to
    // entry 0. Nothing is written on a reset edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_ptr;
        w_wdata = '0;
        if (!rst) begin
            if (!w_run) begin
                w_we = 1'b1;
            end else if (RegWrite && (WriteReg != '0)) begin
                w_we    = 1'b1;
                w_waddr = WriteReg;
                w_wdata = WriteData;
            end
        end
    end

    // Storage carries no reset so it can infer as RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding match logic, present only when BYPASS is enabled.
    // ------------------------------------------------------------------
    if (BYPASS != 0) begin : g_bypass
        assign w_fwd1 = RegWrite && (WriteReg == ReadReg1);
        assign w_fwd2 = RegWrite && (WriteReg == ReadReg2);
    end else begin : g_no_bypass
        assign w_fwd1 = 1'b0;
        assign w_fwd2 = 1'b0;
    end

    // ------------------------------------------------------------------
    // Read ports: zero while clearing and for $zero, else forwarded data,
    // else stored data. Each port is resolved independently.
    // ------------------------------------------------------------------
    always_comb begin
        ReadData1 = '0;
        if (w_run && (ReadReg1 != '0)) begin
            ReadData1 = w_fwd1 ? WriteData : r_mem[ReadReg1];
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (w_run && (ReadReg2 != '0)) begin
            ReadData2 = w_fwd2 ? WriteData : r_mem[ReadReg2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file. Two instances share
//                all inputs, one with forwarding and one without, and are
//                compared against a behavioural reference model (plain array
//                plus a "cycles since reset released" counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [WIDTH-1:0]  rd1_b, rd2_b, rd1_n, rd2_n;
    logic              rdy_b, rdy_n;

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .Ready(rdy_b)
    );

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_n), .ReadData2(rd2_n), .Ready(rdy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [WIDTH-1:0] m_reg [DEPTH];
    int               m_cnt;     // clock edges since rst was released
    bit               m_ready;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input logic [ADDR_W-1:0] a, input bit fwd);
        if (!m_ready || a == 0) return '0;
        if (fwd && RegWrite && WriteReg == a) return WriteData;
        return m_reg[a];
    endfunction

    // Check outputs mid-cycle, then advance one edge and update the model.
    task automatic cycle();
        @(negedge clk);
        check("ready_b", {31'd0, rdy_b}, {31'd0, m_ready});
        check("ready_n", {31'd0, rdy_n}, {31'd0, m_ready});
        check("rd1_b", rd1_b, exp_rd(ReadReg1, 1'b1));
        check("rd2_b", rd2_b, exp_rd(ReadReg2, 1'b1));
        check("rd1_n", rd1_n, exp_rd(ReadReg1, 1'b0));
        check("rd2_n", rd2_n, exp_rd(ReadReg2, 1'b0));
        @(posedge clk);
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_reg[i]) m_reg[i] = '0;
            end
        end else if (RegWrite && WriteReg != 0) begin
            m_reg[WriteReg] = WriteData;
        end
        #1;
    endtask

    task automatic drive(input bit r, input bit we, input int wa,
                         input logic [WIDTH-1:0] wd, input int a1, input int a2);
        rst       = r;
        RegWrite  = we;
        WriteReg  = ADDR_W'(wa);
        WriteData = wd;
        ReadReg1  = ADDR_W'(a1);
        ReadReg2  = ADDR_W'(a2);
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 'x;
        m_cnt   = 0;
        m_ready = 1'b0;
        drive(1, 0, 0, 0, 0, 0);

        // Reset for 2 edges, then count the sweep.
        cycle();
        cycle();
        check("ready_after_rst", {31'd0, rdy_b}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            // Write attempt on the 10th edge of the sweep must be dropped.
            if (i == 9) drive(0, 1, 3, 32'h0000ABCD, 3, 9);
            else        drive(0, 0, 0, 0, i, 31 - i);
            cycle();
        end
        check("ready_after_sweep", {31'd0, rdy_b}, 32'd1);

        // All registers read zero.
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, i, 31 - i);
            cycle();
        end

        // Basic write/read.
        drive(0, 1, 5, 32'hDEADBEEF, 0, 0); cycle();
        drive(0, 1, 31, 32'h00000001, 0, 0); cycle();
        drive(0, 0, 0, 0, 5, 31); #1;
        check("r5_const", rd1_b, 32'hDEADBEEF);
        check("r31_const", rd2_n, 32'h00000001);
        cycle();

        // $zero protection.
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0); #1;
        check("zero_during_b", rd1_b, 32'h0);
        check("zero_during_n", rd2_n, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 0, 0); cycle();

        // Bypass.
        drive(0, 1, 7, 32'h11111111, 0, 0); cycle();
        drive(0, 1, 7, 32'h22222222, 7, 7); #1;
        check("byp_on_before", rd1_b, 32'h22222222);
        check("byp_off_before", rd1_n, 32'h11111111);
        cycle();
        drive(0, 0, 0, 0, 7, 7); #1;
        check("byp_off_after", rd1_n, 32'h22222222);
        cycle();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1),
                  $urandom_range(0, DEPTH - 1), $urandom,
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) WriteReg = ReadReg1;
            cycle();
        end
        // Let any sweep finish.
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(0, 0, 0, 0, i % DEPTH, 0);
            cycle();
        end

        // Reset mid-operation with a write presented on the reset edge.
        drive(0, 1, 9, 32'h00001234, 9, 0); cycle();
        drive(1, 1, 9, 32'h00005678, 9, 0); cycle();
        check("ready_drop", {31'd0, rdy_b}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 9, 9);
            cycle();
        end
        check("ready_back", {31'd0, rdy_n}, 32'd1);
        check("r9_cleared", rd1_b, 32'h0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
